uart_rx_ctrl: RTL and testbench

//  Controller that sequences the UART receiver core and buffers its output for the host bus.

---
 rtl/uart_rx_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the UART receiver core (ack handshake), buffers
// received bytes in a show-ahead FIFO for the host, and raises one host
// interrupt for FIFO threshold, idle timeout or overrun.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AW          = 3,
  parameter logic [31:0] DEFAULT_DIV = 32'd868
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [31:0]   cfg_div,
  input  logic          rx_enable,
  input  logic [AW:0]   thresh,
  input  logic [31:0]   timeout_cyc,
  input  logic          ovr_clr,
  input  logic          pop,
  output logic [31:0]   clk_div,
  output logic          urx_irq_en,
  input  logic          urx_irq,
  input  logic [7:0]    urx_data,
  output logic          urx_read,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          irq
);

  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  state_e        state_q, state_d;

  logic [31:0]   clk_div_q, clk_div_d;
  logic          irq_en_q, irq_en_d;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic          overrun_q, overrun_d;
  logic [31:0]   timer_q, timer_d;
  logic          irq_q, irq_d;

  logic          ack;
  logic          fifo_empty;
  logic          fifo_full;
  logic          do_push;
  logic          do_pop;
  logic          drop;
  logic          activity;
  logic          thr_hit;
  logic          tmo_flag;

  // ---------------------------------------------------------------------------
  // Handshake FSM with the receiver core
  // ---------------------------------------------------------------------------

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: one ack per byte, then wait for the core to drop its irq
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (urx_irq && irq_en_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!urx_irq) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the ack strobe doubles as the FIFO push request
  always_comb begin
    ack = 1'b0;
    unique case (state_q)
      IDLE:    ack = urx_irq && irq_en_q;
      DRAIN:   ack = 1'b0;
      default: ack = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver configuration
  // ---------------------------------------------------------------------------

  // Next divisor and irq enable
  always_comb begin
    clk_div_d = clk_div_q;
    if (cfg_we) begin
      clk_div_d = cfg_div;
    end
    irq_en_d = rx_enable;
  end

  // Configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q <= DEFAULT_DIV;
      irq_en_q  <= 1'b0;
    end else begin
      clk_div_q <= clk_div_d;
      irq_en_q  <= irq_en_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------

  // Push/pop qualification; a full FIFO still accepts when a pop frees a slot
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_LVL);
    do_pop     = pop && !fifo_empty;
    do_push    = ack && (!fifo_full || do_pop);
    drop       = ack && fifo_full && !do_pop;
    activity   = do_push || do_pop;
  end

  // Next pointers, occupancy and memory contents
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = urx_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + LVL_ONE;
      2'b01:   count_d = count_q - LVL_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers; reset discards contents
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Overrun, idle timer and host interrupt
  // ---------------------------------------------------------------------------

  // Sticky overrun: a drop wins over a simultaneous clear
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Idle timer: restarts on any FIFO activity or when empty, saturates
  always_comb begin
    timer_d = timer_q;
    if (activity || fifo_empty) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + 32'd1;
    end
  end

  // Interrupt sources from current-cycle state
  always_comb begin
    thr_hit  = (thresh != '0) && (count_q >= thresh);
    tmo_flag = (timeout_cyc != '0) && (timer_q >= timeout_cyc) &&
               !activity && !fifo_empty;
    irq_d    = thr_hit || tmo_flag || overrun_q;
  end

  // Status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
    end
  end

  // Output drive
  always_comb begin
    clk_div    = clk_div_q;
    urx_irq_en = irq_en_q;
    urx_read   = ack;
    rd_data    = mem_q[rd_ptr_q];
    rd_valid   = !fifo_empty;
    level      = count_q;
    overrun    = overrun_q;
    irq        = irq_q;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: drives a receiver-core model and a host,
// keeps a reference model of FIFO/interrupt behaviour, and checks the byte
// stream through a scoreboard monitored on the DUT read port.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [31:0]   cfg_div;
  logic          rx_enable;
  logic [AW:0]   thresh;
  logic [31:0]   timeout_cyc;
  logic          ovr_clr;
  logic          pop;
  logic [31:0]   clk_div;
  logic          urx_irq_en;
  logic          urx_irq;
  logic [7:0]    urx_data;
  logic          urx_read;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW:0]   level;
  logic          overrun;
  logic          irq;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH(DEPTH),
    .AW(AW),
    .DEFAULT_DIV(32'd868)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_div(cfg_div),
    .rx_enable(rx_enable), .thresh(thresh), .timeout_cyc(timeout_cyc),
    .ovr_clr(ovr_clr), .pop(pop), .clk_div(clk_div), .urx_irq_en(urx_irq_en),
    .urx_irq(urx_irq), .urx_data(urx_data), .urx_read(urx_read),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level),
    .overrun(overrun), .irq(irq)
  );

  int tests = 0;
  int fails = 0;
  int acks  = 0;
  int pop_pct = 0;

  // scoreboard of bytes expected at the FIFO head, in order
  byte unsigned sb[$];

  // reference model state (values the DUT registers should hold now)
  int          m_level;
  bit          m_ovr, m_irq, m_en, m_drain;
  logic [31:0] m_div;
  longint      cyc, last_act;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rnd_pop();
    return ($urandom_range(0, 99) < pop_pct);
  endfunction

  task automatic model_reset();
    m_level  = 0;
    m_ovr    = 0;
    m_irq    = 0;
    m_en     = 0;
    m_drain  = 0;
    m_div    = 32'd868;
    last_act = cyc + 1;
  endtask

  // one clock cycle: drive pop, check DUT against model, advance model at the edge
  task automatic step(input bit p);
    bit e_ack, dpop, accept, tmo;
    pop = p;
    @(negedge clk);
    chk("level", level, m_level);
    chk("rd_valid", rd_valid, m_level != 0);
    chk("overrun", overrun, m_ovr);
    chk("irq", irq, m_irq);
    chk("clk_div", clk_div, m_div);
    chk("urx_irq_en", urx_irq_en, m_en);
    e_ack = urx_irq && m_en && !m_drain;
    chk("urx_read", urx_read, e_ack);
    @(posedge clk);
    if (rst) begin
      model_reset();
      sb.delete();
    end else begin
      if (e_ack) acks++;
      dpop   = pop && (m_level > 0);
      accept = e_ack && ((m_level < DEPTH) || dpop);
      tmo    = (timeout_cyc != 0) && (m_level > 0) && !(accept || dpop) &&
               ((cyc - last_act) >= longint'({32'd0, timeout_cyc}));
      m_irq  = ((thresh != 0) && (m_level >= int'(thresh))) || tmo || m_ovr;
      if (e_ack && !accept) m_ovr = 1;
      else if (ovr_clr)     m_ovr = 0;
      if (accept || dpop || m_level == 0) last_act = cyc + 1;
      if (accept) sb.push_back(urx_data);
      m_level = m_level + int'(accept) - int'(dpop);
      if (e_ack) m_drain = 1;
      else if (m_drain && !urx_irq) m_drain = 0;
      m_en = rx_enable;
      if (cfg_we) m_div = cfg_div;
    end
    cyc++;
    #1;
    cfg_we  = 1'b0;
    ovr_clr = 1'b0;
  endtask

  // receiver core model: present a byte, wait for ack, hold irq, then drop it
  task automatic send(input byte unsigned b, input int hold, input bit pop_first);
    bit got;
    int a0;
    urx_data = b;
    urx_irq  = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      a0 = acks;
      step((n == 0) ? pop_first : rnd_pop());
      got = (acks != a0);
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL ack_wait: actual=no ack required=ack within 40 cycles (t=%0t)", $time);
    end
    for (int h = 0; h < hold; h++) step(rnd_pop());
    urx_irq  = 1'b0;
    urx_data = 8'($urandom_range(0, 255));
    step(rnd_pop());
  endtask

  task automatic drain_fifo();
    for (int k = 0; k < DEPTH + 2 && m_level > 0; k++) step(1'b1);
    step(1'b0);
  endtask

  // monitor: head byte must match scoreboard whenever the FIFO shows data
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_data: actual=%0d required=no data (scoreboard empty)", rd_data);
      end else begin
        chk("rd_data", rd_data, sb[0]);
        if (pop) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    rst = 1'b1; cfg_we = 1'b0; cfg_div = '0; rx_enable = 1'b0; thresh = '0;
    timeout_cyc = '0; ovr_clr = 1'b0; pop = 1'b0; urx_irq = 1'b0; urx_data = '0;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    step(1'b0);
    rst = 1'b0;
    chk("rst_clk_div", clk_div, 868);
    chk("rst_level", level, 0);
    chk("rst_irq", irq, 0);
    chk("rst_urx_irq_en", urx_irq_en, 0);

    // three bytes, then pop them back
    rx_enable = 1'b1;
    step(1'b0);
    a0 = acks;
    send(8'h41, 2, 1'b0);
    send(8'h42, 2, 1'b0);
    send(8'h43, 2, 1'b0);
    chk("t1_acks", acks - a0, 3);
    chk("t1_level", level, 3);
    chk("t1_head", rd_data, 8'h41);
    repeat (3) step(1'b1);
    step(1'b0);
    chk("t1_empty", rd_valid, 0);

    // irq held long after ack: still a single capture
    a0 = acks;
    send(8'h55, 5, 1'b0);
    chk("t2_acks", acks - a0, 1);
    chk("t2_level", level, 1);
    drain_fifo();

    // fill, overflow, clear, overflow with simultaneous pop
    for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 2, 1'b0);
    chk("t3_full", level, DEPTH);
    send(8'h99, 2, 1'b0);
    chk("t3_overrun", overrun, 1);
    chk("t3_irq", irq, 1);
    chk("t3_head", rd_data, 8'h10);
    chk("t3_level", level, DEPTH);
    ovr_clr = 1'b1;
    step(1'b0);
    chk("t3_ovr_clr", overrun, 0);
    step(1'b0);
    send(8'h99, 2, 1'b1);
    chk("t3_ovr_stay0", overrun, 0);
    chk("t3_level2", level, DEPTH);
    chk("t3_head2", rd_data, 8'h11);
    drain_fifo();

    // level threshold
    thresh = 4'(4);
    for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 2, 1'b0);
    chk("t4_irq_hi", irq, 1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    chk("t4_irq_lo", irq, 0);
    thresh = '0;
    drain_fifo();

    // idle timeout: push edge E0, send returns after E3; irq rises at E101
    timeout_cyc = 32'd100;
    send(8'h5A, 2, 1'b0);
    repeat (97) step(1'b0);
    chk("t5_tmo_early", irq, 0);
    step(1'b0);
    chk("t5_tmo_fire", irq, 1);
    step(1'b1);
    step(1'b0);
    chk("t5_tmo_clear", irq, 0);
    timeout_cyc = '0;

    // divisor load, then reset in the middle of DRAIN
    cfg_we = 1'b1;
    cfg_div = 32'd434;
    step(1'b0);
    chk("t6_div", clk_div, 434);
    urx_data = 8'h77;
    urx_irq  = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b1;
    urx_irq = 1'b0;
    step(1'b0);
    rst = 1'b0;
    chk("t6_rst_div", clk_div, 868);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_ovr", overrun, 0);
    chk("t6_rst_irq", irq, 0);
    chk("t6_rst_en", urx_irq_en, 0);
    chk("t6_rst_read", urx_read, 0);
    step(1'b0);

    // randomized traffic
    pop_pct = 30;
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 9) == 0) thresh = (AW + 1)'($urandom_range(0, DEPTH));
      if ($urandom_range(0, 9) == 0)
        timeout_cyc = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(3, 25)) : 32'd0;
      if ($urandom_range(0, 7) == 0) ovr_clr = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        rx_enable = 1'b0;
        repeat ($urandom_range(1, 4)) step(rnd_pop());
        rx_enable = 1'b1;
      end
      send(8'($urandom_range(0, 255)), $urandom_range(0, 4), rnd_pop());
      repeat ($urandom_range(0, 3)) step(rnd_pop());
    end
    pop_pct = 0;
    drain_fifo();
    chk("final_empty", rd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
